// File: rtl/delta_engine.sv
// delta_engine: backprop delta unit. Hidden mode runs an NN-step MAC across
// NC parallel lanes and gates the result by ReLU'(z). Output mode computes
// ReLU(z) - t. The saturated result forks to two valid/ready consumers.

// Per-lane accumulator and delta finaliser
module delta_engine_lane #(
  parameter int WD = 8,
  parameter int WA = 10,
  parameter int WS = 18,
  parameter int WF = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_mac,
  input  logic          i_mode,
  input  logic [WD-1:0] i_w,
  input  logic [WD-1:0] i_d,
  input  logic [WA-1:0] i_z,
  input  logic [WD-1:0] i_t,
  output logic [WD-1:0] o_res
);
  localparam logic signed [WS-1:0] S_MAX = WS'((2**(WD-1)) - 1);
  localparam logic signed [WS-1:0] S_MIN = ~S_MAX;  // -2^(WD-1)
  localparam logic signed [WA-1:0] Z_MAX = WA'((2**(WD-1)) - 1);

  logic signed [2*WD-1:0] w_prod;
  logic signed [WS-1:0]   r_acc;
  logic signed [WS-1:0]   w_shf;
  logic signed [WD:0]     w_diff;
  logic [WD-1:0]          w_hsat, w_y, w_osat;
  logic                   w_zpos;

  assign w_prod = $signed(i_w) * $signed(i_d);

  // Accumulate w*delta each MAC cycle; cleared when a hidden transaction is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_mac) r_acc <= r_acc + {{(WS-2*WD){w_prod[2*WD-1]}}, w_prod};
  end

  // Hidden: ReLU'(z) * sat(acc >>> WF). Output: sat(sat(ReLU(z)) - t) at WD+1 bits
  always_comb begin
    w_shf = r_acc >>> WF;
    if (w_shf > S_MAX)      w_hsat = S_MAX[WD-1:0];
    else if (w_shf < S_MIN) w_hsat = S_MIN[WD-1:0];
    else                    w_hsat = w_shf[WD-1:0];
    w_zpos = !i_z[WA-1] && (i_z != '0);
    if (i_z[WA-1])                w_y = '0;
    else if ($signed(i_z) > Z_MAX) w_y = Z_MAX[WD-1:0];
    else                          w_y = i_z[WD-1:0];
    w_diff = $signed({1'b0, w_y}) - $signed({i_t[WD-1], i_t});
    if (w_diff[WD] != w_diff[WD-1])
      w_osat = w_diff[WD] ? {1'b1, {(WD-1){1'b0}}} : {1'b0, {(WD-1){1'b1}}};
    else
      w_osat = w_diff[WD-1:0];
    if (i_mode) o_res = w_zpos ? w_hsat : '0;
    else        o_res = w_osat;
  end
endmodule

// Top: join, MAC sequencing, finalise and fork
module delta_engine #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int NN = 4,
  parameter int WI = 4,
  parameter int WF = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iMode,
  input  logic                iValid_AS_Accum,
  output logic                oReady_AS_Accum,
  input  logic [NC*($clog2(NP)+WI+WF)-1:0] iData_AS_Accum,
  input  logic                iValid_AS_Weight,
  output logic                oReady_AS_Weight,
  input  logic [NN*NC*(WI+WF)-1:0] iData_AS_Weight,
  input  logic                iValid_AS_Delta,
  output logic                oReady_AS_Delta,
  input  logic [NN*(WI+WF)-1:0] iData_AS_Delta,
  input  logic                iValid_AS_Target,
  output logic                oReady_AS_Target,
  input  logic [NC*(WI+WF)-1:0] iData_AS_Target,
  output logic                oValid_BM_Delta0,
  input  logic                iReady_BM_Delta0,
  output logic [NC*(WI+WF)-1:0] oData_BM_Delta0,
  output logic                oValid_BM_Delta1,
  input  logic                iReady_BM_Delta1,
  output logic [NC*(WI+WF)-1:0] oData_BM_Delta1
);
  localparam int WD = WI + WF;
  localparam int WA = $clog2(NP) + WI + WF;
  localparam int WS = 2*WD + $clog2(NN) + 1;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN, S_OUT} state_t;

  state_t                        r_state, w_next;
  logic                          r_mode;
  logic [NC-1:0][WA-1:0]         r_z;
  logic [NN-1:0][NC-1:0][WD-1:0] r_w;
  logic [NN-1:0][WD-1:0]         r_d;
  logic [NC-1:0][WD-1:0]         r_t, r_data, w_res;
  logic [KW-1:0]                 r_k;
  logic                          r_v0, r_v1;
  logic                          w_join_h, w_join_o, w_accept;
  logic                          w_hs0, w_hs1, w_last, w_clr, w_mac;

  assign w_hs0  = r_v0 && iReady_BM_Delta0;
  assign w_hs1  = r_v1 && iReady_BM_Delta1;
  assign w_last = (r_k == KW'(NN - 1));
  assign w_clr  = w_accept && iMode;
  assign w_mac  = (r_state == S_MAC);

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: OUT returns to IDLE once both branches have handshaked
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = iMode ? S_MAC : S_FIN;
      S_MAC:   if (w_last) w_next = S_FIN;
      S_FIN:   w_next = S_OUT;
      S_OUT:   if ((!r_v0 || w_hs0) && (!r_v1 || w_hs1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Join readies: only in IDLE and only with the complete valid set for the mode
  always_comb begin
    w_join_h         = iMode && iValid_AS_Accum && iValid_AS_Weight && iValid_AS_Delta;
    w_join_o         = !iMode && iValid_AS_Accum && iValid_AS_Target;
    w_accept         = iRST && (r_state == S_IDLE) && (w_join_h || w_join_o);
    oReady_AS_Accum  = w_accept;
    oReady_AS_Weight = w_accept && iMode;
    oReady_AS_Delta  = w_accept && iMode;
    oReady_AS_Target = w_accept && !iMode;
  end

  // Capture the transaction at acceptance; step the MAC index
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_mode <= 1'b0;
      r_z    <= '0;
      r_w    <= '0;
      r_d    <= '0;
      r_t    <= '0;
      r_k    <= '0;
    end else if (w_accept) begin
      r_mode <= iMode;
      r_z    <= iData_AS_Accum;
      r_w    <= iData_AS_Weight;
      r_d    <= iData_AS_Delta;
      r_t    <= iData_AS_Target;
      r_k    <= '0;
    end else if (w_mac) begin
      r_k    <= r_k + KW'(1);
    end
  end

  // Register the result in FIN; each branch valid drops after its own handshake
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_data <= '0;
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
    end else if (r_state == S_FIN) begin
      r_data <= w_res;
      r_v0   <= 1'b1;
      r_v1   <= 1'b1;
    end else begin
      if (w_hs0) r_v0 <= 1'b0;
      if (w_hs1) r_v1 <= 1'b0;
    end
  end

  for (genvar c = 0; c < NC; c++) begin : g_lane
    delta_engine_lane #(.WD(WD), .WA(WA), .WS(WS), .WF(WF)) u_lane (
      .i_clk   (iCLK),
      .i_rst_n (iRST),
      .i_clr   (w_clr),
      .i_mac   (w_mac),
      .i_mode  (r_mode),
      .i_w     (r_w[r_k][c]),
      .i_d     (r_d[r_k]),
      .i_z     (r_z[c]),
      .i_t     (r_t[c]),
      .o_res   (w_res[c])
    );
  end

  assign oValid_BM_Delta0 = r_v0;
  assign oValid_BM_Delta1 = r_v1;
  assign oData_BM_Delta0  = r_data;
  assign oData_BM_Delta1  = r_data;
endmodule

// File: tb/tb_delta_engine.sv
// tb_delta_engine: directed scenarios plus random transactions, checked every
// cycle against a queue-based behavioural model of the delta unit.
module tb_delta_engine;
  localparam int NP = 4, NC = 2, NN = 2, WI = 4, WF = 4;
  localparam int WD = WI + WF;
  localparam int WA = $clog2(NP) + WD;
  localparam int ZW = NC*WA, WW = NN*NC*WD, DW = NN*WD, TW = NC*WD;
  localparam int SMAX = 2**(WD-1) - 1;
  localparam int SMIN = -SMAX - 1;

  logic          iCLK = 0, iRST = 1, iMode = 0;
  logic          iValid_AS_Accum = 0, iValid_AS_Weight = 0, iValid_AS_Delta = 0, iValid_AS_Target = 0;
  logic          oReady_AS_Accum, oReady_AS_Weight, oReady_AS_Delta, oReady_AS_Target;
  logic [ZW-1:0] iData_AS_Accum = '0;
  logic [WW-1:0] iData_AS_Weight = '0;
  logic [DW-1:0] iData_AS_Delta = '0;
  logic [TW-1:0] iData_AS_Target = '0;
  logic          oValid_BM_Delta0, oValid_BM_Delta1;
  logic          iReady_BM_Delta0 = 0, iReady_BM_Delta1 = 0;
  logic [TW-1:0] oData_BM_Delta0, oData_BM_Delta1;

  delta_engine #(.NP(NP), .NC(NC), .NN(NN), .WI(WI), .WF(WF)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMode(iMode),
    .iValid_AS_Accum(iValid_AS_Accum), .oReady_AS_Accum(oReady_AS_Accum), .iData_AS_Accum(iData_AS_Accum),
    .iValid_AS_Weight(iValid_AS_Weight), .oReady_AS_Weight(oReady_AS_Weight), .iData_AS_Weight(iData_AS_Weight),
    .iValid_AS_Delta(iValid_AS_Delta), .oReady_AS_Delta(oReady_AS_Delta), .iData_AS_Delta(iData_AS_Delta),
    .iValid_AS_Target(iValid_AS_Target), .oReady_AS_Target(oReady_AS_Target), .iData_AS_Target(iData_AS_Target),
    .oValid_BM_Delta0(oValid_BM_Delta0), .iReady_BM_Delta0(iReady_BM_Delta0), .oData_BM_Delta0(oData_BM_Delta0),
    .oValid_BM_Delta1(oValid_BM_Delta1), .iReady_BM_Delta1(iReady_BM_Delta1), .oData_BM_Delta1(oData_BM_Delta1)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  function automatic int sat(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic logic [TW-1:0] model(input logic m, input logic [ZW-1:0] z,
                                          input logic [WW-1:0] w, input logic [DW-1:0] d,
                                          input logic [TW-1:0] t);
    logic [TW-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      int zc, tc, acc, v;
      zc = $signed(z[c*WA +: WA]);
      tc = $signed(t[c*WD +: WD]);
      if (m) begin
        acc = 0;
        for (int n = 0; n < NN; n++) begin
          int wv, dv;
          wv = $signed(w[(n*NC+c)*WD +: WD]);
          dv = $signed(d[n*WD +: WD]);
          acc += wv * dv;
        end
        v = (zc > 0) ? sat(acc >>> WF) : 0;
      end else begin
        v = sat(sat(zc < 0 ? 0 : zc) - tc);
      end
      r[c*WD +: WD] = v[WD-1:0];
    end
    return r;
  endfunction

  function automatic logic [ZW-1:0] pz(input int a, input int b);
    return {WA'(b), WA'(a)};
  endfunction
  function automatic logic [TW-1:0] p2(input int a, input int b);
    return {WD'(b), WD'(a)};
  endfunction
  // args in w(n,c) order: w(0,0), w(0,1), w(1,0), w(1,1)
  function automatic logic [WW-1:0] pw(input int w00, input int w01, input int w10, input int w11);
    return {WD'(w11), WD'(w10), WD'(w01), WD'(w00)};
  endfunction

  // ---------------- checking ----------------
  typedef struct {
    logic [TW-1:0] data;
    int            due;
    logic          lit_en;
    logic [TW-1:0] lit;
  } exp_t;

  exp_t          q[$];
  int            vec = 0, errs = 0;
  logic          busy = 0, dn0 = 0, dn1 = 0;
  int            bcnt = 0;
  logic          lit_en = 0;
  logic [TW-1:0] lit_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge iCLK) begin
    logic er;
    if (!iRST) begin
      chk("rst_valid0", oValid_BM_Delta0, 0);
      chk("rst_valid1", oValid_BM_Delta1, 0);
      chk("rst_rdy_accum", oReady_AS_Accum, 0);
      chk("rst_rdy_weight", oReady_AS_Weight, 0);
      chk("rst_rdy_delta", oReady_AS_Delta, 0);
      chk("rst_rdy_target", oReady_AS_Target, 0);
      q.delete();
      busy = 0; dn0 = 0; dn1 = 0; bcnt = 0;
    end else begin
      er = !busy && (iMode ? (iValid_AS_Accum && iValid_AS_Weight && iValid_AS_Delta)
                           : (iValid_AS_Accum && iValid_AS_Target));
      chk("rdy_accum", oReady_AS_Accum, er);
      chk("rdy_weight", oReady_AS_Weight, er && iMode);
      chk("rdy_delta", oReady_AS_Delta, er && iMode);
      chk("rdy_target", oReady_AS_Target, er && !iMode);
      if (er) begin
        q.push_back('{model(iMode, iData_AS_Accum, iData_AS_Weight, iData_AS_Delta, iData_AS_Target),
                      cyc + 1 + (iMode ? NN + 1 : 1), lit_en, lit_val});
        busy = 1; bcnt = 0;
      end
      if (q.size() != 0 && cyc >= q[0].due) begin
        chk("valid0", oValid_BM_Delta0, !dn0);
        chk("valid1", oValid_BM_Delta1, !dn1);
        if (oValid_BM_Delta0) chk("data0", oData_BM_Delta0, q[0].data);
        if (oValid_BM_Delta1) chk("data1", oData_BM_Delta1, q[0].data);
        if (cyc == q[0].due && q[0].lit_en) chk("literal", oData_BM_Delta0, q[0].lit);
        if (oValid_BM_Delta0 && iReady_BM_Delta0) dn0 = 1;
        if (oValid_BM_Delta1 && iReady_BM_Delta1) dn1 = 1;
        if (dn0 && dn1) begin
          void'(q.pop_front());
          dn0 = 0; dn1 = 0; busy = 0;
        end
      end else begin
        chk("early_valid0", oValid_BM_Delta0, 0);
        chk("early_valid1", oValid_BM_Delta1, 0);
      end
      if (busy) begin
        bcnt++;
        if (bcnt > 200) begin
          chk("busy_cycles", bcnt, 200);
          q.delete();
          busy = 0; dn0 = 0; dn1 = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic rnd_rdy = 0, f0 = 1, f1 = 1;
  always @(posedge iCLK) begin
    #1;
    if (rnd_rdy) begin
      iReady_BM_Delta0 = ($urandom_range(0, 3) != 0);
      iReady_BM_Delta1 = ($urandom_range(0, 1) == 1);
    end else begin
      iReady_BM_Delta0 = f0;
      iReady_BM_Delta1 = f1;
    end
  end

  // vm = {Accum, Weight, Delta, Target} valids
  task automatic present(input logic m, input logic [ZW-1:0] z, input logic [WW-1:0] w,
                         input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [3:0] vm);
    @(posedge iCLK); #1;
    iMode = m;
    iData_AS_Accum = z; iData_AS_Weight = w; iData_AS_Delta = d; iData_AS_Target = t;
    {iValid_AS_Accum, iValid_AS_Weight, iValid_AS_Delta, iValid_AS_Target} = vm;
  endtask

  task automatic wait_accept();
    int g = 0;
    @(negedge iCLK);
    while (!(iValid_AS_Accum && oReady_AS_Accum) && g < 400) begin
      @(negedge iCLK);
      g++;
    end
    @(posedge iCLK); #1;
    {iValid_AS_Accum, iValid_AS_Weight, iValid_AS_Delta, iValid_AS_Target} = 4'b0000;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 400) begin
      @(negedge iCLK);
      g++;
    end
    @(negedge iCLK);
  endtask

  initial begin
    // reset with a full hidden join offered: readies must stay low
    #2 iRST = 0;
    iMode = 1;
    {iValid_AS_Accum, iValid_AS_Weight, iValid_AS_Delta, iValid_AS_Target} = 4'b1110;
    repeat (3) @(negedge iCLK);
    @(posedge iCLK); #1;
    iRST = 1;
    {iValid_AS_Accum, iValid_AS_Weight, iValid_AS_Delta, iValid_AS_Target} = 4'b0000;

    // hidden basic -> (48, 0)
    lit_en = 1; lit_val = p2(48, 0);
    present(1, pz(16, -16), pw(16, 16, 32, 16), p2(16, 16), '0, 4'b1110);
    wait_accept(); wait_idle();

    // saturation high and low
    lit_val = p2(127, 127);
    present(1, pz(16, 16), pw(127, 127, 127, 127), p2(127, 127), '0, 4'b1110);
    wait_accept(); wait_idle();
    lit_val = p2(-128, -128);
    present(1, pz(16, 16), pw(127, 127, 127, 127), p2(-128, -128), '0, 4'b1110);
    wait_accept(); wait_idle();

    // output mode -> (24, -16); weight/delta valids up but their readies must stay low
    lit_val = p2(24, -16);
    present(0, pz(40, -8), pw(1, 2, 3, 4), p2(5, 6), p2(16, 16), 4'b1111);
    wait_accept(); wait_idle();

    // fork skew: branch 1 stalls, next transaction offered immediately
    f0 = 1; f1 = 0;
    lit_val = p2(48, 0);
    present(1, pz(16, -16), pw(16, 16, 32, 16), p2(16, 16), '0, 4'b1110);
    wait_accept();
    lit_val = p2(24, -16);
    present(0, pz(40, -8), '0, '0, p2(16, 16), 4'b1001);
    begin
      int g = 0;
      @(negedge iCLK);
      while (!oValid_BM_Delta1 && g < 50) begin @(negedge iCLK); g++; end
    end
    repeat (3) @(negedge iCLK);
    f1 = 1;
    wait_accept(); wait_idle();

    // partial join: accum+weight only for 5 cycles, then delta arrives
    lit_val = p2(48, 0);
    present(1, pz(16, -16), pw(16, 16, 32, 16), p2(16, 16), '0, 4'b1100);
    repeat (5) @(negedge iCLK);
    @(posedge iCLK); #1;
    iValid_AS_Delta = 1;
    wait_accept(); wait_idle();

    // reset during MAC at k=1, then a clean transaction
    lit_en = 0;
    present(1, pz(16, -16), pw(16, 16, 32, 16), p2(16, 16), '0, 4'b1110);
    wait_accept();
    @(posedge iCLK); #2;
    iRST = 0;
    {iValid_AS_Accum, iValid_AS_Weight, iValid_AS_Delta, iValid_AS_Target} = 4'b1110;
    repeat (2) @(negedge iCLK);
    @(posedge iCLK); #1;
    iRST = 1;
    {iValid_AS_Accum, iValid_AS_Weight, iValid_AS_Delta, iValid_AS_Target} = 4'b0000;
    repeat (3) @(negedge iCLK);
    lit_en = 1; lit_val = p2(48, 0);
    present(1, pz(16, -16), pw(16, 16, 32, 16), p2(16, 16), '0, 4'b1110);
    wait_accept(); wait_idle();

    // random transactions, random output readies, next offer made while busy
    lit_en = 0;
    rnd_rdy = 1;
    repeat (300) begin
      logic          m;
      logic [ZW-1:0] z;
      m = 1'($urandom_range(0, 1));
      z = ZW'($urandom);
      if ($urandom_range(0, 7) == 0) z[WA-1:0] = '0;
      present(m, z, WW'($urandom), DW'($urandom), TW'($urandom),
              m ? {3'b111, 1'($urandom_range(0, 1))}
                : {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
      wait_accept();
    end
    wait_idle();
    rnd_rdy = 0;
    repeat (2) @(negedge iCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
